// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline freeze/flush controller.
package pipeline_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Register-hazard detector: decides whether the ID instruction must wait.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_src_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hz
);

  logic exe_match;
  logic mem_match;

  assign exe_match = id_src_valid &
                     ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
  assign mem_match = id_src_valid &
                     ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    if (fwd_en) begin
      hz = exe_match & exe_mem_r_en & exe_wb_en;
    end else begin
      hz = (exe_match & exe_wb_en) | (mem_match & mem_wb_en);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline freeze/flush/stall controller with memory watchdog and
// saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_src_valid,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic             freeze,
  output logic             flush,
  output logic             stall_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              hz;
  logic              stall_c, flush_c, freeze_c;

  hazard_detect u_hazard (
    .fwd_en       (fwd_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_src_valid (id_src_valid),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hz           (hz)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    freeze_c = 1'b0;
    case (state_q)
      RUN: begin
        stall_c  = mem_req & ~mem_ready;
        flush_c  = exe_branch_taken & ~stall_c;
        freeze_c = hz & ~flush_c & ~stall_c;
        // The entry cycle is already the first stalled cycle.
        if (stall_c) begin
          wait_d = WAIT_W'(1);
          if (MEM_TIMEOUT <= 1) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        stall_c = ~mem_ready;
        if (mem_ready) begin
          state_d = RUN;
        end else if (int'(wait_q) + 1 >= MEM_TIMEOUT) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HALT: begin
        freeze_c = 1'b1;
        if (err_clr) begin
          state_d = RUN;
          err_d   = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Controls are forced low while reset is held, independent of inputs.
  assign stall_all = stall_c & rst;
  assign flush     = flush_c & rst;
  assign freeze    = freeze_c & rst;
  assign mem_error = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((freeze_c | stall_c) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_c && !(&flush_cnt_q))              flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected controls queued per step, counters modelled.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en, id_two_src, id_src_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       exe_branch_taken, mem_req, mem_ready, err_clr, cnt_clr;
  logic       freeze, flush, stall_all, mem_error;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string tag;
    logic  f;
    logic  fl;
    logic  st;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_stall = 0;
  int    exp_flush = 0;
  logic  exp_err = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src_valid(id_src_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .freeze(freeze), .flush(flush),
    .stall_all(stall_all), .mem_error(mem_error), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fwd_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_src_valid = 0;
    exe_dest = 4'd9; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4'd10; mem_wb_en = 0;
    exe_branch_taken = 0; mem_req = 0; mem_ready = 0; err_clr = 0; cnt_clr = 0;
  endtask

  // Inputs are set by the caller just after a rising edge; controls are
  // checked mid-cycle, registered state just after the following edge.
  task automatic cyc(input string tag, input logic f, input logic fl, input logic st,
                     input logic err_after);
    item_t it;
    sb.push_back('{tag: tag, f: f, fl: fl, st: st});
    #3;
    it = sb.pop_front();
    chk({it.tag, ".freeze"}, 32'(freeze), 32'(it.f));
    chk({it.tag, ".flush"}, 32'(flush), 32'(it.fl));
    chk({it.tag, ".stall_all"}, 32'(stall_all), 32'(it.st));
    @(posedge clk);
    if (cnt_clr) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if ((it.f | it.st) && exp_stall != 15) exp_stall++;
      if (it.fl && exp_flush != 15) exp_flush++;
    end
    exp_err = err_after;
    #1;
    chk({it.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({it.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    chk({it.tag, ".mem_error"}, 32'(mem_error), 32'(exp_err));
    $display("step %-22s freeze=%0b flush=%0b stall_all=%0b stall_cnt=%0d flush_cnt=%0d mem_error=%0b",
             it.tag, it.f, it.fl, it.st, stall_cnt, flush_cnt, mem_error);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".freeze"}, 32'(freeze), 0);
    chk({tag, ".flush"}, 32'(flush), 0);
    chk({tag, ".stall_all"}, 32'(stall_all), 0);
    chk({tag, ".mem_error"}, 32'(mem_error), 0);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 0);
  endtask

  initial begin
    // Reset held with every trigger active: outputs must stay low.
    rst = 0;
    idle();
    id_src_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
    mem_req = 1; exe_branch_taken = 1;
    #2;
    chk_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset_held");
    idle();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    // No forwarding
    id_src_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
    cyc("nofwd_exe", 1, 0, 0, 0);
    exe_dest = 5;
    cyc("nofwd_miss", 0, 0, 0, 0);
    mem_dest = 3; mem_wb_en = 1;
    cyc("nofwd_mem", 1, 0, 0, 0);
    fwd_en = 1;
    cyc("fwd_mem_bypass", 0, 0, 0, 0);

    // Forwarding, load-use on src2
    id_src1 = 0; id_src2 = 7; id_two_src = 1; exe_dest = 7;
    exe_wb_en = 1; exe_mem_r_en = 1; mem_wb_en = 0;
    cyc("loaduse", 1, 0, 0, 0);
    id_two_src = 0;
    cyc("loaduse_src2_unused", 0, 0, 0, 0);
    id_two_src = 1; id_src_valid = 0;
    cyc("loaduse_invalid", 0, 0, 0, 0);

    // Branch beats hazard
    id_src_valid = 1; exe_branch_taken = 1;
    cyc("branch_hz", 0, 1, 0, 0);

    // Memory wait of three cycles
    idle();
    mem_req = 1; mem_ready = 0;
    repeat (3) cyc("memwait", 0, 0, 1, 0);
    mem_ready = 1;
    cyc("mem_ready", 0, 0, 0, 0);
    mem_req = 0; mem_ready = 0; exe_branch_taken = 1;
    cyc("run_after_wait", 0, 1, 0, 0);

    // Ready on the entry cycle: no wait state entered
    idle();
    mem_req = 1; mem_ready = 1;
    cyc("ready_on_entry", 0, 0, 0, 0);
    mem_req = 0; mem_ready = 0;
    cyc("no_wait_after_ready", 0, 0, 0, 0);

    // Watchdog
    mem_req = 1; mem_ready = 0;
    repeat (3) cyc("wd_stall", 0, 0, 1, 0);
    cyc("wd_timeout", 0, 0, 1, 1);
    exe_branch_taken = 1;
    cyc("halt", 1, 0, 0, 1);
    err_clr = 1;
    cyc("halt_clr", 1, 0, 0, 0);
    idle();
    cyc("run_after_clr", 0, 0, 0, 0);

    // Counter saturation and clear
    id_src_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
    repeat (20) cyc("sat", 1, 0, 0, 0);
    chk("stall_saturated", 32'(stall_cnt), 32'd15);
    cnt_clr = 1;
    cyc("cnt_clr", 1, 0, 0, 0);
    idle();

    // Asynchronous reset while waiting on memory
    mem_req = 1; mem_ready = 0;
    cyc("pre_rst_wait", 0, 0, 1, 0);
    #2;
    rst = 0;
    #1;
    exp_stall = 0; exp_flush = 0; exp_err = 0;
    chk_reset_state("async_rst");
    mem_req = 0; mem_ready = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    cyc("post_rst_no_stall", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
